// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester bridging a cmd/rsp handshake onto one APB transfer at a time.
// Optional ACCESS wait timeout compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is registered, so it first rises one edge after reset release
                    if (cmd_valid && cmd_ready) begin
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_slverr <= pslverr;
                        state      <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // completer never answered: abort and report an error
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_slverr <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized bench for apb_master with a transaction-timeline reference model.
module tb_apb_master;

    localparam int T = 4;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_slverr;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          hold;
        bit          to;
        int          s;
    } txn_t;

    txn_t cur, prev;
    int   cyc = 0;
    int   rel_cyc = 0;
    bit   in_reset = 1'b1;
    int   vectors = 0;
    int   errors = 0;
    logic [31:0] seen_rdata;
    logic        seen_slverr;
    int          seen_k;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t blank();
        txn_t t;
        t = '{addr: 0, wr: 0, wdata: 0, rdata: 0, err: 0, acc: 0, hold: 0, to: 0, s: -1000000};
        return t;
    endfunction

    // Reference model: each transfer is a timeline measured from its SETUP cycle
    always @(negedge pclk) begin
        int   k;
        int   ph;
        txn_t m;
        if (in_reset) begin
            chk("rst_psel", psel, 0);
            chk("rst_penable", penable, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_slverr", rsp_slverr, 0);
            chk("rst_paddr", paddr, 0);
            chk("rst_pwrite", pwrite, 0);
            chk("rst_pwdata", pwdata, 0);
        end else begin
            k = cyc - cur.s;
            m = (k < 0) ? prev : cur;
            if (k < 0) ph = 0;
            else if (k == 0) ph = 1;
            else if (k <= cur.acc) ph = 2;
            else if (k <= cur.acc + 1 + cur.hold) ph = 3;
            else ph = 0;
            chk("psel", psel, (ph == 1 || ph == 2));
            chk("penable", penable, (ph == 2));
            chk("cmd_ready", cmd_ready, (ph == 0 && cyc > rel_cyc));
            chk("rsp_valid", rsp_valid, (ph == 3));
            chk("paddr", paddr, m.addr);
            chk("pwrite", pwrite, m.wr);
            chk("pwdata", pwdata, m.wdata);
            if (ph == 3) begin
                chk("rsp_rdata", rsp_rdata, (m.to || m.wr) ? 32'h0 : m.rdata);
                chk("rsp_slverr", rsp_slverr, m.to ? 1'b1 : m.err);
            end
        end
    end

    task automatic publish(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                           input logic [31:0] rd, input bit err, input int w, input int h);
        prev = cur;
        cur.addr = a; cur.wr = wr; cur.wdata = wd; cur.rdata = rd; cur.err = err;
        cur.hold = h;
`ifdef APB_MASTER_TIMEOUT_EN
        cur.to  = (w >= T);
        cur.acc = (w >= T) ? T : w + 1;
`else
        cur.to  = 1'b0;
        cur.acc = w + 1;
`endif
        cur.s = cyc + 1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_wdata = wd;
        pready = 1'b0; pslverr = $urandom; prdata = $urandom; rsp_ready = $urandom;
    endtask

    task automatic run_txn(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                           input logic [31:0] rd, input bit err, input int w, input int h);
        publish(a, wr, wd, rd, err, w, h);
        @(posedge pclk); #1;
        cmd_valid = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom;
        pready = $urandom; pslverr = 1'b1; prdata = $urandom;
        for (int i = 1; i <= cur.acc; i++) begin
            @(posedge pclk); #1;
            cmd_valid = $urandom; cmd_addr = $urandom;
            if (i == cur.acc && !cur.to) begin
                pready = 1'b1; prdata = rd; pslverr = err;
            end else begin
                pready = 1'b0; pslverr = 1'b1; prdata = $urandom;
            end
        end
        for (int i = 0; i <= h; i++) begin
            @(posedge pclk); #1;
            if (i == 0) begin
                seen_rdata = rsp_rdata; seen_slverr = rsp_slverr; seen_k = cyc - cur.s;
            end
            pready = $urandom; pslverr = $urandom; prdata = $urandom;
            rsp_ready = (i == h);
            cmd_valid = (i < h);
        end
        @(posedge pclk); #1;
        cmd_valid = 1'b0; rsp_ready = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            cmd_valid = 1'b0; cmd_addr = $urandom; rsp_ready = $urandom;
            pready = $urandom; pslverr = $urandom;
        end
    endtask

    initial begin
        cur = blank(); prev = blank();
        preset_n = 1'b0; in_reset = 1'b1;
        cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_wdata = 0;
        rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0;
        repeat (3) @(posedge pclk);
        #1; preset_n = 1'b1; in_reset = 1'b0; rel_cyc = cyc;
        chk("cmd_ready_first_cycle", cmd_ready, 0);
        @(posedge pclk); #1;
        chk("cmd_ready_after_release", cmd_ready, 1);

        run_txn(32'h10, 1'b1, 32'hA5A5_0001, 32'h1234_5678, 1'b0, 0, 0);
        chk("wr0_rsp_latency", seen_k, 2);
        chk("wr0_rdata", seen_rdata, 32'h0);
        chk("wr0_slverr", seen_slverr, 1'b0);

        run_txn(32'h24, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1);
        chk("rd3_rdata", seen_rdata, 32'hDEAD_BEEF);
        chk("rd3_latency", seen_k, 5);

        run_txn(32'h40, 1'b1, 32'h0BAD_0BAD, 32'h0, 1'b1, 0, 0);
        chk("err_slverr", seen_slverr, 1'b1);
        run_txn(32'h44, 1'b0, 32'h0, 32'h0000_CAFE, 1'b0, 2, 0);
        chk("noerr_slverr", seen_slverr, 1'b0);

        run_txn(32'h80, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, 1, 5);

`ifdef APB_MASTER_TIMEOUT_EN
        run_txn(32'hC0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 10, 0);
        chk("to_slverr", seen_slverr, 1'b1);
        chk("to_rdata", seen_rdata, 32'h0);
        chk("to_latency", seen_k, T + 1);
`endif

        for (int n = 0; n < 40; n++) begin
            run_txn($urandom, 1'($urandom), $urandom, $urandom, 1'($urandom),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // abort a transfer with reset while it sits in ACCESS
        publish(32'h1234, 1'b0, 32'h0, 32'h0, 1'b0, 5, 0);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        #1; in_reset = 1'b1; preset_n = 1'b0;
        #1;
        chk("async_psel", psel, 0);
        chk("async_penable", penable, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge pclk);
        #1;
        cur = blank(); prev = blank();
        preset_n = 1'b1; in_reset = 1'b0; rel_cyc = cyc;
        chk("rel_cmd_ready_low", cmd_ready, 0);
        @(posedge pclk); #1;
        chk("rel_cmd_ready_high", cmd_ready, 1);
        chk("rel_no_rsp", rsp_valid, 0);

        run_txn(32'h55, 1'b1, 32'h7777_0000, 32'h0, 1'b0, 1, 1);
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
